// File: rtl/uart_echo_fifo.sv
// uart_echo_fifo: 16x-oversampled UART receiver feeding a FIFO that is echoed back out
// through a matching transmitter; frame format, baud rate and depth are parameters.
module uart_echo_fifo #(
   parameter int CLK_FREQ   = 25_000_000,
   parameter int BAUD_RATE  = 115200,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          echo_en,
   input  logic                          uart_rx,
   output logic                          uart_tx,
   output logic [DATA_BITS-1:0]          rx_data,
   output logic                          rx_valid,
   output logic                          err_frame,
   output logic                          err_parity,
   output logic                          overflow,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
   localparam int OSR = (CLK_FREQ + 8 * BAUD_RATE) / (16 * BAUD_RATE);
   localparam int CW  = OSR > 1 ? $clog2(OSR) : 1;
   localparam int AW  = $clog2(FIFO_DEPTH);

   typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

   state_t               rx_state, rx_next, tx_state, tx_next;
   logic [CW-1:0]        tcnt;
   logic                 tick, rxs, rx_maj, par_ok, rx_eval, push, pop, full, empty, tx_step;
   logic [1:0]           sync, rx_vote;
   logic [3:0]           rx_sub, tx_sub;
   logic [2:0]           rx_bit, tx_bit;
   logic [DATA_BITS-1:0] rx_sh, tx_sh;
   logic                 rx_pb, tx_par;
   logic [AW:0]          wp, rp;
   logic [DATA_BITS-1:0] mem [FIFO_DEPTH];

   assign tick = tcnt == CW'(OSR - 1);
   assign rxs  = sync[1];

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         tcnt <= '0;
         sync <= 2'b11;
      end else begin
         tcnt <= tick ? '0 : tcnt + CW'(1);
         sync <= {sync[0], uart_rx};
      end

   // rx_vote holds the samples from sub-counts 7 and 8; rxs is the third at sub-count 9
   assign rx_maj  = (rx_vote[1] & rx_vote[0]) | (rx_vote[1] & rxs) | (rx_vote[0] & rxs);
   assign par_ok  = PARITY == 0 || ((^rx_sh ^ rx_pb) == (PARITY == 1));
   assign rx_eval = tick && rx_state == STOP && rx_sub == 4'd9;
   assign push    = rx_eval && rx_maj && par_ok;

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         rx_state <= IDLE;
         tx_state <= IDLE;
      end else begin
         rx_state <= rx_next;
         tx_state <= tx_next;
      end

   always_comb begin
      rx_next = rx_state;
      if (tick)
         case (rx_state)
            IDLE:    if (!rxs) rx_next = START;
            START:   if (rx_sub == 4'd9 && rx_maj) rx_next = IDLE;
                     else if (rx_sub == 4'd15) rx_next = DATA;
            DATA:    if (rx_sub == 4'd15 && rx_bit == 3'(DATA_BITS - 1)) rx_next = PARITY != 0 ? PAR : STOP;
            PAR:     if (rx_sub == 4'd15) rx_next = STOP;
            STOP:    if (rx_sub == 4'd9) rx_next = IDLE;
            default: rx_next = IDLE;
         endcase
   end

   // the start-detect tick counts as sub-count 0, so the next tick is 1
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         rx_sub  <= '0;
         rx_bit  <= '0;
         rx_vote <= '0;
         rx_sh   <= '0;
         rx_pb   <= 1'b0;
      end else if (tick) begin
         rx_sub <= rx_state == IDLE ? 4'd1 : rx_sub + 4'd1;
         rx_bit <= rx_state != DATA ? 3'd0 : rx_bit + 3'(rx_sub == 4'd15);
         if (rx_sub == 4'd7 || rx_sub == 4'd8) rx_vote <= {rx_vote[0], rxs};
         if (rx_state == DATA && rx_sub == 4'd9) rx_sh <= {rx_maj, rx_sh[DATA_BITS-1:1]};
         if (rx_state == PAR && rx_sub == 4'd9) rx_pb <= rx_maj;
      end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         rx_valid   <= 1'b0;
         err_frame  <= 1'b0;
         err_parity <= 1'b0;
         overflow   <= 1'b0;
         rx_data    <= '0;
      end else begin
         rx_valid   <= push;
         err_frame  <= rx_eval && !rx_maj;
         err_parity <= rx_eval && rx_maj && !par_ok;
         overflow   <= overflow | (push && full && !pop);
         if (push) rx_data <= rx_sh;
      end

   assign empty      = wp == rp;
   assign full       = wp == {~rp[AW], rp[AW-1:0]};
   assign fifo_level = wp - rp;

   // a pop in the same cycle frees the slot, so a push into a full FIFO still lands
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         wp <= '0;
         rp <= '0;
      end else begin
         if (push && (!full || pop)) wp <= wp + (AW+1)'(1);
         if (pop) rp <= rp + (AW+1)'(1);
      end

   always_ff @(posedge clk)
      if (push && (!full || pop)) mem[wp[AW-1:0]] <= rx_sh;

   assign pop     = tick && tx_state == IDLE && echo_en && !empty;
   assign tx_step = tick && (tx_state == IDLE || tx_sub == 4'd15);

   always_comb begin
      tx_next = tx_state;
      if (tick)
         case (tx_state)
            IDLE:    if (echo_en && !empty) tx_next = START;
            START:   if (tx_sub == 4'd15) tx_next = DATA;
            DATA:    if (tx_sub == 4'd15 && tx_bit == 3'(DATA_BITS - 1)) tx_next = PARITY != 0 ? PAR : STOP;
            PAR:     if (tx_sub == 4'd15) tx_next = STOP;
            STOP:    if (tx_sub == 4'd15 && tx_bit == 3'(STOP_BITS - 1)) tx_next = IDLE;
            default: tx_next = IDLE;
         endcase
   end

   // tx_bit counts data bits in DATA and stop bits in STOP; the line is set one bit ahead
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         tx_sub  <= '0;
         tx_bit  <= '0;
         tx_sh   <= '0;
         tx_par  <= 1'b0;
         uart_tx <= 1'b1;
      end else begin
         if (tick) tx_sub <= tx_state == IDLE ? 4'd0 : tx_sub + 4'd1;
         if (tx_step) begin
            tx_bit  <= tx_next != tx_state ? 3'd0 : tx_bit + 3'd1;
            if (tx_state == DATA) tx_sh <= tx_sh >> 1;
            uart_tx <= tx_next == START ? 1'b0 :
                       tx_next == DATA  ? (tx_state == DATA ? tx_sh[1] : tx_sh[0]) :
                       tx_next == PAR   ? tx_par : 1'b1;
         end
         if (pop) begin
            tx_sh  <= mem[rp[AW-1:0]];
            tx_par <= (PARITY == 1) ^ (^mem[rp[AW-1:0]]);
         end
      end
endmodule

// File: tb/tb_uart_echo_fifo.sv
// tb_uart_echo_fifo: drives serial frames into two configurations of the echo core
// and checks received characters, flags, FIFO level and the echoed serial stream.
module tb_uart_echo_fifo;
   localparam int B0 = 224, B1 = 64, OSR0 = 14, OSR1 = 4;

   typedef struct {
      int         inst;
      logic [7:0] d;
      logic       p;
      logic       s1;
      logic       s2;
      int         t0;
   } frame_t;

   logic       clk = 1'b0, rst = 1'b1, en0 = 1'b0, en1 = 1'b0, rx0 = 1'b1, rx1 = 1'b1;
   logic       tx0, rv0, fe0, pe0, ov0, tx1, rv1, fe1, pe1, ov1;
   logic [7:0] rxd0;
   logic [6:0] rxd1;
   logic [4:0] lvl0;
   logic [2:0] lvl1;

   int         total = 0, bad = 0, cyc = 0, rv_cyc = 0;
   int         nfe0 = 0, npe0 = 0, nfe1 = 0, npe1 = 0;
   frame_t     echoes[$];
   logic [7:0] got0[$];
   logic [6:0] got1[$];

   uart_echo_fifo u0 (
      .clk(clk), .rst(rst), .echo_en(en0), .uart_rx(rx0), .uart_tx(tx0), .rx_data(rxd0),
      .rx_valid(rv0), .err_frame(fe0), .err_parity(pe0), .overflow(ov0), .fifo_level(lvl0)
   );

   uart_echo_fifo #(
      .CLK_FREQ(25_000_000), .BAUD_RATE(390_625), .DATA_BITS(7), .PARITY(2),
      .STOP_BITS(2), .FIFO_DEPTH(4)
   ) u1 (
      .clk(clk), .rst(rst), .echo_en(en1), .uart_rx(rx1), .uart_tx(tx1), .rx_data(rxd1),
      .rx_valid(rv1), .err_frame(fe1), .err_parity(pe1), .overflow(ov1), .fifo_level(lvl1)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (rv0) begin
         got0.push_back(rxd0);
         rv_cyc = cyc;
      end
      if (rv1) got1.push_back(rxd1);
      if (fe0) nfe0++;
      if (pe0) npe0++;
      if (fe1) nfe1++;
      if (pe1) npe1++;
   end

   function automatic logic txv(input int i);
      return i == 0 ? tx0 : tx1;
   endfunction

   task automatic mon(input int i);
      int bt = i == 0 ? B0 : B1;
      int nb = i == 0 ? 8 : 7;
      frame_t f;
      forever begin
         @(negedge clk);
         if (!rst && txv(i) == 1'b0) begin
            f.inst = i; f.t0 = cyc; f.d = '0; f.p = 1'b0; f.s2 = 1'b1;
            repeat (bt / 2) @(negedge clk);
            for (int k = 0; k < nb; k++) begin
               repeat (bt) @(negedge clk);
               f.d[k] = txv(i);
            end
            if (i == 1) begin repeat (bt) @(negedge clk); f.p = txv(i); end
            repeat (bt) @(negedge clk);
            f.s1 = txv(i);
            if (i == 1) begin repeat (bt) @(negedge clk); f.s2 = txv(i); end
            echoes.push_back(f);
         end
      end
   endtask

   initial fork
      mon(0);
      mon(1);
   join_none

   task automatic set_rx(input int i, input logic v);
      if (i == 0) rx0 = v; else rx1 = v;
   endtask

   task automatic send(input int i, input logic [7:0] d, input logic flip, input logic stop);
      int bt = i == 0 ? B0 : B1;
      int nb = i == 0 ? 8 : 7;
      @(negedge clk);
      set_rx(i, 1'b0);
      repeat (bt) @(negedge clk);
      for (int k = 0; k < nb; k++) begin
         set_rx(i, d[k]);
         repeat (bt) @(negedge clk);
      end
      if (i == 1) begin
         set_rx(i, (^d[6:0]) ^ flip);
         repeat (bt) @(negedge clk);
      end
      set_rx(i, stop);
      repeat (bt) @(negedge clk);
      if (i == 1) begin
         set_rx(i, 1'b1);
         repeat (bt) @(negedge clk);
      end
      set_rx(i, 1'b1);
   endtask

   task automatic clr();
      echoes.delete(); got0.delete(); got1.delete();
      nfe0 = 0; npe0 = 0; nfe1 = 0; npe1 = 0;
   endtask

   task automatic wait_echoes(input int n, input int limit);
      int c = 0;
      while (echoes.size() < n && c < limit) begin @(negedge clk); c++; end
      total++; if (echoes.size() < n) begin bad++; $display("FAIL echo_wait got=%0d want=%0d", echoes.size(), n); end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      total++; if (tx0 !== 1'b1) begin bad++; $display("FAIL rst_tx0 got=%b want=1", tx0); end
      total++; if (tx1 !== 1'b1) begin bad++; $display("FAIL rst_tx1 got=%b want=1", tx1); end
      total++; if ({rv0, fe0, pe0, ov0} !== 4'b0) begin bad++; $display("FAIL rst_flags0 got=%b want=0000", {rv0, fe0, pe0, ov0}); end
      total++; if ({rv1, fe1, pe1, ov1} !== 4'b0) begin bad++; $display("FAIL rst_flags1 got=%b want=0000", {rv1, fe1, pe1, ov1}); end
      total++; if (rxd0 !== 8'h00) begin bad++; $display("FAIL rst_rxdata got=%h want=00", rxd0); end
      total++; if (lvl0 !== 5'd0 || lvl1 !== 3'd0) begin bad++; $display("FAIL rst_level got=%0d/%0d want=0/0", lvl0, lvl1); end
      rst = 1'b0;
      repeat (50) @(negedge clk);
      total++; if (tx0 !== 1'b1 || tx1 !== 1'b1) begin bad++; $display("FAIL idle_tx got=%b%b want=11", tx0, tx1); end
   endtask

   task automatic test_echo_a5();
      int lat;
      clr(); en0 = 1'b1;
      send(0, 8'hA5, 1'b0, 1'b1);
      wait_echoes(1, 4000);
      total++; if (got0.size() != 1 || got0[0] !== 8'hA5) begin bad++; $display("FAIL a5_rx got_n=%0d want=a5", got0.size()); end
      total++; if (rxd0 !== 8'hA5) begin bad++; $display("FAIL a5_rxdata got=%h want=a5", rxd0); end
      total++; if (echoes.size() < 1 || echoes[0].d !== 8'hA5 || echoes[0].s1 !== 1'b1) begin bad++; $display("FAIL a5_echo got=%h want=a5", echoes.size() > 0 ? echoes[0].d : 8'h0); end
      lat = echoes.size() > 0 ? echoes[0].t0 - rv_cyc : -1;
      total++; if (lat < 1 || lat > OSR0 + 1) begin bad++; $display("FAIL a5_tx_latency got=%0d want=1..%0d", lat, OSR0 + 1); end
   endtask

   task automatic test_random_echo();
      logic [7:0] sent[$];
      logic [7:0] d;
      clr(); en0 = 1'b1;
      for (int i = 0; i < 5; i++) begin
         d = 8'($urandom_range(0, 255));
         sent.push_back(d);
         send(0, d, 1'b0, 1'b1);
      end
      wait_echoes(5, 6000);
      for (int i = 0; i < 5; i++) begin
         total++; if (i >= echoes.size() || echoes[i].d !== sent[i] || echoes[i].s1 !== 1'b1) begin bad++; $display("FAIL rand_echo%0d got=%h want=%h", i, i < echoes.size() ? echoes[i].d : 8'h0, sent[i]); end
         total++; if (i >= got0.size() || got0[i] !== sent[i]) begin bad++; $display("FAIL rand_rx%0d want=%h", i, sent[i]); end
      end
      total++; if (ov0 !== 1'b0) begin bad++; $display("FAIL rand_overflow got=%b want=0", ov0); end
   endtask

   task automatic test_frame_glitch();
      clr(); en0 = 1'b1;
      send(0, 8'h3C, 1'b0, 1'b0);
      repeat (3000) @(negedge clk);
      total++; if (nfe0 != 1) begin bad++; $display("FAIL frame_err got=%0d want=1", nfe0); end
      total++; if (got0.size() != 0 || echoes.size() != 0 || lvl0 !== 5'd0) begin bad++; $display("FAIL frame_drop got=%0d/%0d/%0d want=0/0/0", got0.size(), echoes.size(), lvl0); end
      total++; if (npe0 != 0) begin bad++; $display("FAIL frame_parity got=%0d want=0", npe0); end
      for (int g = 0; g < 4; g++) begin
         rx0 = 1'b0;
         repeat (3) @(negedge clk);
         rx0 = 1'b1;
         repeat (300 + 5 * g) @(negedge clk);
      end
      total++; if (nfe0 != 1 || npe0 != 0 || got0.size() != 0 || lvl0 !== 5'd0) begin bad++; $display("FAIL glitch got=fe%0d pe%0d rx%0d lvl%0d want=fe1 pe0 rx0 lvl0", nfe0, npe0, got0.size(), lvl0); end
   endtask

   task automatic test_parity();
      logic [7:0] exp[$];
      logic [7:0] d;
      logic       f;
      int         nperr = 0;
      clr(); en1 = 1'b0;
      send(1, 8'h41, 1'b0, 1'b1);
      repeat (20) @(negedge clk);
      total++; if (lvl1 !== 3'd1 || got1.size() != 1 || got1[0] !== 7'h41) begin bad++; $display("FAIL par_good got_lvl=%0d got_n=%0d want=1/1", lvl1, got1.size()); end
      send(1, 8'h41, 1'b1, 1'b1);
      repeat (20) @(negedge clk);
      total++; if (npe1 != 1 || nfe1 != 0) begin bad++; $display("FAIL par_bad_flag got=%0d want=1", npe1); end
      total++; if (lvl1 !== 3'd1 || got1.size() != 1) begin bad++; $display("FAIL par_bad_drop got_lvl=%0d got_n=%0d want=1/1", lvl1, got1.size()); end
      en1 = 1'b1;
      wait_echoes(1, 2000);
      total++; if (echoes.size() < 1 || echoes[0].d !== 8'h41 || echoes[0].p !== 1'b0 || echoes[0].s1 !== 1'b1 || echoes[0].s2 !== 1'b1) begin bad++; $display("FAIL par_echo got=%h want=41 p0", echoes.size() > 0 ? echoes[0].d : 8'h0); end
      clr();
      for (int i = 0; i < 6; i++) begin
         d = 8'($urandom_range(0, 127));
         f = 1'($urandom_range(0, 1));
         send(1, d, f, 1'b1);
         if (f) nperr++; else exp.push_back(d);
      end
      wait_echoes(exp.size(), 3000);
      total++; if (npe1 != nperr) begin bad++; $display("FAIL par_rand_flags got=%0d want=%0d", npe1, nperr); end
      foreach (exp[i]) begin
         total++; if (i >= echoes.size() || echoes[i].d !== exp[i] || echoes[i].p !== ^exp[i]) begin bad++; $display("FAIL par_rand_echo%0d want=%h", i, exp[i]); end
      end
   endtask

   task automatic test_overflow();
      clr(); en1 = 1'b0;
      total++; if (ov1 !== 1'b0) begin bad++; $display("FAIL ovf_pre got=%b want=0", ov1); end
      for (int v = 1; v <= 4; v++) send(1, 8'(v), 1'b0, 1'b1);
      repeat (20) @(negedge clk);
      total++; if (lvl1 !== 3'd4 || ov1 !== 1'b0) begin bad++; $display("FAIL ovf_full got_lvl=%0d got_ovf=%b want=4/0", lvl1, ov1); end
      for (int v = 5; v <= 6; v++) send(1, 8'(v), 1'b0, 1'b1);
      repeat (20) @(negedge clk);
      total++; if (lvl1 !== 3'd4 || ov1 !== 1'b1) begin bad++; $display("FAIL ovf_set got_lvl=%0d got_ovf=%b want=4/1", lvl1, ov1); end
      total++; if (got1.size() != 6) begin bad++; $display("FAIL ovf_valid got=%0d want=6", got1.size()); end
      en1 = 1'b1;
      wait_echoes(4, 4000);
      repeat (1500) @(negedge clk);
      total++; if (echoes.size() != 4) begin bad++; $display("FAIL ovf_echo_n got=%0d want=4", echoes.size()); end
      for (int i = 0; i < 4; i++) begin
         total++; if (i >= echoes.size() || echoes[i].d !== 8'(i + 1)) begin bad++; $display("FAIL ovf_echo%0d want=%0d", i, i + 1); end
      end
      total++; if (lvl1 !== 3'd0 || ov1 !== 1'b1) begin bad++; $display("FAIL ovf_after got_lvl=%0d got_ovf=%b want=0/1", lvl1, ov1); end
   endtask

   task automatic test_back_to_back();
      int gap;
      clr(); en1 = 1'b1;
      send(1, 8'h00, 1'b0, 1'b1);
      send(1, 8'h7F, 1'b0, 1'b1);
      wait_echoes(2, 3000);
      total++; if (got1.size() != 2 || got1[0] !== 7'h00 || got1[1] !== 7'h7F) begin bad++; $display("FAIL b2b_rx got_n=%0d want=2", got1.size()); end
      total++; if (echoes.size() < 2 || echoes[0].d !== 8'h00 || echoes[1].d !== 8'h7F || echoes[1].s2 !== 1'b1) begin bad++; $display("FAIL b2b_echo got_n=%0d want=2", echoes.size()); end
      gap = echoes.size() < 2 ? 0 : echoes[1].t0 - echoes[0].t0 - 9 * B1;
      total++; if (gap < 2 * 16 * OSR1) begin bad++; $display("FAIL b2b_gap got=%0d want>=%0d", gap, 2 * 16 * OSR1); end
   endtask

   task automatic test_reset_mid();
      int c = 0;
      clr(); en0 = 1'b0;
      send(0, 8'h96, 1'b0, 1'b1);
      send(0, 8'h33, 1'b0, 1'b1);
      repeat (20) @(negedge clk);
      total++; if (lvl0 !== 5'd2) begin bad++; $display("FAIL rmid_pre_level got=%0d want=2", lvl0); end
      en0 = 1'b1;
      while (tx0 !== 1'b0 && c < 100) begin @(negedge clk); c++; end
      total++; if (tx0 !== 1'b0) begin bad++; $display("FAIL rmid_start got=%b want=0", tx0); end
      repeat (4 * B0 + B0 / 2) @(negedge clk);
      total++; if (tx0 !== 1'b0 || lvl0 !== 5'd1) begin bad++; $display("FAIL rmid_bit3 got_tx=%b got_lvl=%0d want=0/1", tx0, lvl0); end
      rst = 1'b1;
      #1;
      total++; if (tx0 !== 1'b1) begin bad++; $display("FAIL rmid_tx got=%b want=1", tx0); end
      total++; if (lvl0 !== 5'd0) begin bad++; $display("FAIL rmid_level got=%0d want=0", lvl0); end
      en0 = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (2500) @(negedge clk);
      clr(); en0 = 1'b1;
      send(0, 8'h5A, 1'b0, 1'b1);
      wait_echoes(1, 4000);
      repeat (500) @(negedge clk);
      total++; if (echoes.size() != 1 || echoes[0].d !== 8'h5A || echoes[0].s1 !== 1'b1) begin bad++; $display("FAIL rmid_echo got_n=%0d want=1 x 5a", echoes.size()); end
      total++; if (got0.size() != 1 || got0[0] !== 8'h5A || ov0 !== 1'b0) begin bad++; $display("FAIL rmid_rx got_n=%0d want=1", got0.size()); end
   endtask

   initial begin
      test_reset();
      test_echo_a5();
      test_random_echo();
      test_frame_glitch();
      test_parity();
      test_overflow();
      test_back_to_back();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
